// File: rtl/d_write_buffer_if.sv
// Bundle of the store-side, conflict-check and AXI write-channel signals of
// the data-cache write buffer; "master" is the buffer, "slave" its environment.
interface d_write_buffer_if;
  logic        push_req;
  logic [31:0] push_addr;
  logic [1:0]  push_size;
  logic [3:0]  push_strb;
  logic [31:0] push_data;
  logic        push_ready;
  logic [31:0] chk_addr;
  logic        chk_conflict;
  logic        wb_empty;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [3:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  push_req, push_addr, push_size, push_strb, push_data, chk_addr,
           awready, wready, bvalid,
    output push_ready, chk_conflict, wb_empty, awaddr, awsize, awlen, awvalid,
           wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output push_req, push_addr, push_size, push_strb, push_data, chk_addr,
           awready, wready, bvalid,
    input  push_ready, chk_conflict, wb_empty, awaddr, awsize, awlen, awvalid,
           wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/d_write_buffer.sv
// Posted-write FIFO: accepts single-beat stores in one cycle and drains them
// in order as single-beat AXI writes; the head entry stays queued until its B.
module d_write_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic              clk,
  input logic              rst,
  d_write_buffer_if.master bus
);

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RESP
  } state_e;

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  state_e           state_q, state_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [31:0]      awaddr_q, awaddr_d;
  logic [2:0]       awsize_q, awsize_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;

  logic             push_ready;
  logic             push_fire;
  logic             pop_fire;
  logic             awvalid;
  logic             wvalid;
  logic             bready;
  logic             aw_hs;
  logic             w_hs;
  logic [DEPTH-1:0] hit;
  logic             chk_unused;

  // Full is judged on the registered count only, so a same-cycle pop never
  // frees a slot for a same-cycle push.
  assign push_ready = (count_q != CNT_FULL);
  assign push_fire  = bus.push_req & push_ready;
  assign awvalid    = (state_q == S_SEND) & ~aw_done_q;
  assign wvalid     = (state_q == S_SEND) & ~w_done_q;
  assign bready     = (state_q == S_RESP);
  assign aw_hs      = awvalid & bus.awready;
  assign w_hs       = wvalid & bus.wready;
  assign pop_fire   = bus.bvalid & bready;

  // NOTE: storage has no reset; validity comes solely from rd_ptr/count,
  // so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= '{addr: bus.push_addr, size: bus.push_size,
                           strb: bus.push_strb, data: bus.push_data};
    end
  end

  // NOTE: every always_comb assigns defaults first so no path infers a latch.
  always_comb begin
    wr_ptr_d = push_fire ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_fire  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d  = S_SEND;
          awaddr_d = mem_q[rd_ptr_q].addr;
          awsize_d = {1'b0, mem_q[rd_ptr_q].size};
          wdata_d  = mem_q[rd_ptr_q].data;
          wstrb_d  = mem_q[rd_ptr_q].strb;
        end
      end
      S_SEND: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.bvalid) begin
          state_d   = S_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // An entry is live when its distance from rd_ptr is below count.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q) &&
               (mem_q[i].addr[31:2] == bus.chk_addr[31:2]);
    end
  end

  assign chk_unused = &{1'b0, bus.chk_addr[1:0]};

  assign bus.push_ready   = push_ready;
  assign bus.chk_conflict = |hit;
  assign bus.wb_empty     = (count_q == '0) && (state_q == S_IDLE);
  assign bus.awaddr       = awaddr_q;
  assign bus.awsize       = awsize_q;
  assign bus.awlen        = 4'd0;
  assign bus.awvalid      = awvalid;
  assign bus.wdata        = wdata_q;
  assign bus.wstrb        = wstrb_q;
  assign bus.wlast        = 1'b1;
  assign bus.wvalid       = wvalid;
  assign bus.bready       = bready;

endmodule

// File: tb/tb_d_write_buffer.sv
// Self-checking bench for d_write_buffer: an AXI write slave plus a queue-based
// reference of pending stores, with directed and randomized scenarios.
module tb_d_write_buffer;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
  } aw_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  d_write_buffer_if bus_if ();

  d_write_buffer #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: word addresses of stores accepted and not yet retired, plus
  // the expected AW and W beats in push order.
  logic [31:0] pend [$];
  aw_t         aw_exp [$];
  w_t          w_exp [$];
  int          aw_hs_total = 0;
  int          max_pend = 0;

  int b_delay = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  int b_wait = 0;
  bit b_hs_seen = 1'b0;

  // Monitor on the falling edge, AXI B-channel responder just after the rising edge.
  initial begin : monitor_slave
    logic exp_conf;
    aw_t  a;
    w_t   w;
    bus_if.bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        aw_exp.delete();
        w_exp.delete();
        aw_cnt = 0;
        w_cnt = 0;
        b_hs_seen = 1'b0;
      end else begin
        exp_conf = 1'b0;
        foreach (pend[k]) if (pend[k][31:2] == bus_if.chk_addr[31:2]) exp_conf = 1'b1;
        n_cmp++;
        if (bus_if.chk_conflict !== exp_conf) begin
          n_err++;
          $display("FAIL mon_conflict chk_addr=%h got=%b exp=%b", bus_if.chk_addr, bus_if.chk_conflict, exp_conf);
        end
        n_cmp++;
        if (bus_if.push_ready !== (pend.size() != DEPTH)) begin
          n_err++;
          $display("FAIL mon_push_ready got=%b exp=%b", bus_if.push_ready, pend.size() != DEPTH);
        end
        n_cmp++;
        if (bus_if.wb_empty !== (pend.size() == 0)) begin
          n_err++;
          $display("FAIL mon_wb_empty got=%b exp=%b", bus_if.wb_empty, pend.size() == 0);
        end
        if (bus_if.awvalid) begin
          n_cmp++;
          if (bus_if.awlen !== 4'd0) begin
            n_err++;
            $display("FAIL mon_awlen got=%h exp=0", bus_if.awlen);
          end
        end
        if (bus_if.wvalid) begin
          n_cmp++;
          if (bus_if.wlast !== 1'b1) begin
            n_err++;
            $display("FAIL mon_wlast got=%b exp=1", bus_if.wlast);
          end
        end
        b_hs_seen = bus_if.bvalid && bus_if.bready;
        if (b_hs_seen) begin
          n_cmp++;
          if (pend.size() == 0) begin
            n_err++;
            $display("FAIL mon_b_extra got=response exp=none pending");
          end else begin
            void'(pend.pop_front());
          end
        end
        if (bus_if.awvalid && bus_if.awready) begin
          aw_hs_total++;
          aw_cnt++;
          n_cmp++;
          if (aw_exp.size() == 0) begin
            n_err++;
            $display("FAIL mon_aw_extra got=%h exp=none", bus_if.awaddr);
          end else begin
            a = aw_exp.pop_front();
            if ({bus_if.awaddr, bus_if.awsize} !== {a.addr, a.size}) begin
              n_err++;
              $display("FAIL mon_aw got=%h/%0d exp=%h/%0d", bus_if.awaddr, bus_if.awsize, a.addr, a.size);
            end
          end
        end
        if (bus_if.wvalid && bus_if.wready) begin
          w_cnt++;
          n_cmp++;
          if (w_exp.size() == 0) begin
            n_err++;
            $display("FAIL mon_w_extra got=%h exp=none", bus_if.wdata);
          end else begin
            w = w_exp.pop_front();
            if ({bus_if.wdata, bus_if.wstrb} !== {w.data, w.strb}) begin
              n_err++;
              $display("FAIL mon_w got=%h/%h exp=%h/%h", bus_if.wdata, bus_if.wstrb, w.data, w.strb);
            end
          end
        end
        if (bus_if.push_req && bus_if.push_ready) begin
          pend.push_back(bus_if.push_addr);
          aw_exp.push_back('{addr: bus_if.push_addr, size: {1'b0, bus_if.push_size}});
          w_exp.push_back('{data: bus_if.push_data, strb: bus_if.push_strb});
          if (pend.size() > max_pend) max_pend = pend.size();
        end
      end
      @(posedge clk);
      #2;
      if (rst) begin
        bus_if.bvalid = 1'b0;
        aw_cnt = 0;
        w_cnt = 0;
        b_wait = 0;
      end else begin
        if (b_hs_seen) bus_if.bvalid = 1'b0;
        if (!bus_if.bvalid && aw_cnt > 0 && w_cnt > 0) begin
          if (b_wait >= b_delay) begin
            bus_if.bvalid = 1'b1;
            aw_cnt--;
            w_cnt--;
            b_wait = 0;
          end else begin
            b_wait++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [31:0] a, input logic [1:0] s,
                          input logic [3:0] st, input logic [31:0] d);
    bus_if.push_req  = 1'b1;
    bus_if.push_addr = a;
    bus_if.push_size = s;
    bus_if.push_strb = st;
    bus_if.push_data = d;
  endtask

  task automatic set_random_push();
    set_push(32'h1000_0000 + 32'($urandom_range(0, 15)) * 4, 2'($urandom_range(0, 2)),
             4'($urandom_range(1, 15)), $urandom);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (bus_if.wb_empty !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (bus_if.wb_empty !== 1'b1) begin
      n_err++;
      $display("FAIL %s_drain_timeout got=wb_empty %b exp=1 within %0d cycles", name, bus_if.wb_empty, budget);
    end
  endtask

  task automatic test_reset();
    bus_if.push_req = 1'b0;
    bus_if.push_addr = '0;
    bus_if.push_size = '0;
    bus_if.push_strb = '0;
    bus_if.push_data = '0;
    bus_if.chk_addr = '0;
    bus_if.awready = 1'b0;
    bus_if.wready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus_if.awvalid, bus_if.wvalid, bus_if.bready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_valids got=%b exp=000", {bus_if.awvalid, bus_if.wvalid, bus_if.bready});
    end
    n_cmp++;
    if ({bus_if.push_ready, bus_if.wb_empty, bus_if.chk_conflict} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_status got=%b exp=110", {bus_if.push_ready, bus_if.wb_empty, bus_if.chk_conflict});
    end
    n_cmp++;
    if ({bus_if.awaddr, bus_if.wdata, bus_if.wstrb, bus_if.awsize} !== '0) begin
      n_err++;
      $display("FAIL reset_regs got=%h %h %h %h exp=0", bus_if.awaddr, bus_if.wdata, bus_if.wstrb, bus_if.awsize);
    end
    n_cmp++;
    if ({bus_if.awlen, bus_if.wlast} !== 5'b0000_1) begin
      n_err++;
      $display("FAIL reset_const got=%h/%b exp=0/1", bus_if.awlen, bus_if.wlast);
    end
  endtask

  task automatic test_single();
    b_delay = 0;
    bus_if.awready = 1'b1;
    bus_if.wready = 1'b1;
    set_push(32'h1FC0_0100, 2'd2, 4'hF, 32'hDEAD_BEEF);
    step();
    bus_if.push_req = 1'b0;
    n_cmp++;
    if ({bus_if.wb_empty, bus_if.awvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL single_c1 got=empty %b awvalid %b exp=0 0", bus_if.wb_empty, bus_if.awvalid);
    end
    step();
    n_cmp++;
    if ({bus_if.awvalid, bus_if.wvalid} !== 2'b11) begin
      n_err++;
      $display("FAIL single_c2_valid got=%b exp=11", {bus_if.awvalid, bus_if.wvalid});
    end
    n_cmp++;
    if ({bus_if.awaddr, bus_if.awsize, bus_if.wstrb, bus_if.wdata} !== {32'h1FC0_0100, 3'd2, 4'hF, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL single_c2_beat got=%h %0d %h %h exp=1fc00100 2 f deadbeef",
               bus_if.awaddr, bus_if.awsize, bus_if.wstrb, bus_if.wdata);
    end
    step();
    n_cmp++;
    if ({bus_if.bready, bus_if.awvalid, bus_if.wvalid} !== 3'b100) begin
      n_err++;
      $display("FAIL single_c3 got=%b exp=100", {bus_if.bready, bus_if.awvalid, bus_if.wvalid});
    end
    step();
    n_cmp++;
    if (bus_if.wb_empty !== 1'b1) begin
      n_err++;
      $display("FAIL single_c4_empty got=%b exp=1", bus_if.wb_empty);
    end
  endtask

  task automatic test_fill();
    bit seen;
    bus_if.awready = 1'b0;
    bus_if.wready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_random_push();
      step();
    end
    n_cmp++;
    if (bus_if.push_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full got=%b exp=0", bus_if.push_ready);
    end
    set_random_push();
    step();
    step();
    n_cmp++;
    if ({bus_if.push_ready, bus_if.wb_empty} !== 2'b00) begin
      n_err++;
      $display("FAIL fill_ninth_ignored got=%b exp=00", {bus_if.push_ready, bus_if.wb_empty});
    end
    bus_if.awready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.bvalid && bus_if.bready) begin
        seen = 1'b1;
        n_cmp++;
        if (bus_if.push_ready !== 1'b0) begin
          n_err++;
          $display("FAIL fill_pop_cycle_ready got=%b exp=0", bus_if.push_ready);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL fill_first_b_timeout got=none exp=B handshake");
    end
    step();
    n_cmp++;
    if (bus_if.push_ready !== 1'b1) begin
      n_err++;
      $display("FAIL fill_ready_after_pop got=%b exp=1", bus_if.push_ready);
    end
    step();
    bus_if.push_req = 1'b0;
    n_cmp++;
    if (bus_if.push_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_ninth_accepted got=%b exp=0", bus_if.push_ready);
    end
    wait_empty("fill", 200);
  endtask

  task automatic test_skew();
    int n;
    bus_if.awready = 1'b1;
    bus_if.wready = 1'b0;
    set_random_push();
    step();
    bus_if.push_req = 1'b0;
    n = 0;
    while (bus_if.awvalid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    n_cmp++;
    if (bus_if.awvalid !== 1'b1) begin
      n_err++;
      $display("FAIL skew_send_timeout got=%b exp=1", bus_if.awvalid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({bus_if.awvalid, bus_if.wvalid, bus_if.bready} !== 3'b010) begin
        n_err++;
        $display("FAIL skew_hold_%0d got=%b exp=010", i, {bus_if.awvalid, bus_if.wvalid, bus_if.bready});
      end
    end
    bus_if.wready = 1'b1;
    step();
    n_cmp++;
    if ({bus_if.awvalid, bus_if.wvalid, bus_if.bready} !== 3'b001) begin
      n_err++;
      $display("FAIL skew_resp got=%b exp=001", {bus_if.awvalid, bus_if.wvalid, bus_if.bready});
    end
    wait_empty("skew", 50);
  endtask

  task automatic test_conflict();
    bus_if.awready = 1'b0;
    bus_if.wready = 1'b0;
    bus_if.chk_addr = 32'h8000_0007;
    set_push(32'h8000_0004, 2'd0, 4'h1, $urandom);
    #1;
    n_cmp++;
    if (bus_if.chk_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_before_push got=%b exp=0", bus_if.chk_conflict);
    end
    step();
    bus_if.push_req = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.chk_conflict !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_same_word got=%b exp=1", bus_if.chk_conflict);
    end
    bus_if.chk_addr = 32'h8000_0008;
    #1;
    n_cmp++;
    if (bus_if.chk_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_next_word got=%b exp=0", bus_if.chk_conflict);
    end
    bus_if.awready = 1'b1;
    bus_if.wready = 1'b1;
    wait_empty("conflict", 50);
    bus_if.chk_addr = 32'h8000_0007;
    #1;
    n_cmp++;
    if (bus_if.chk_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_after_retire got=%b exp=0", bus_if.chk_conflict);
    end
  endtask

  task automatic test_wrap();
    int pushed;
    int guard;
    int aw_before;
    bit acc;
    b_delay = 1;
    max_pend = 0;
    aw_before = aw_hs_total;
    pushed = 0;
    guard = 0;
    set_random_push();
    while (pushed < 20 && guard < 1000) begin
      bus_if.awready = ($urandom_range(0, 3) != 0);
      bus_if.wready = ($urandom_range(0, 3) != 0);
      bus_if.chk_addr = 32'h1000_0000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      acc = bus_if.push_ready;
      step();
      guard++;
      if (acc) begin
        pushed++;
        set_random_push();
      end
    end
    bus_if.push_req = 1'b0;
    bus_if.awready = 1'b1;
    bus_if.wready = 1'b1;
    wait_empty("wrap", 300);
    n_cmp++;
    if (pushed != 20) begin
      n_err++;
      $display("FAIL wrap_accept got=%0d exp=20", pushed);
    end
    n_cmp++;
    if (aw_hs_total - aw_before != 20 || aw_exp.size() != 0 || w_exp.size() != 0) begin
      n_err++;
      $display("FAIL wrap_drained got=%0d writes, %0d/%0d left exp=20, 0/0",
               aw_hs_total - aw_before, aw_exp.size(), w_exp.size());
    end
    n_cmp++;
    if (max_pend > DEPTH || max_pend < DEPTH) begin
      n_err++;
      $display("FAIL wrap_max_count got=%0d exp=%0d", max_pend, DEPTH);
    end
    b_delay = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    int aw_before;
    bus_if.awready = 1'b0;
    bus_if.wready = 1'b0;
    set_push(32'h2000_0040, 2'd2, 4'hF, $urandom);
    bus_if.chk_addr = 32'h2000_0040;
    step();
    set_random_push();
    step();
    bus_if.push_req = 1'b0;
    n = 0;
    while (bus_if.awvalid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus_if.awvalid, bus_if.wvalid, bus_if.bready} !== 3'b000) begin
      n_err++;
      $display("FAIL rstmid_valids got=%b exp=000", {bus_if.awvalid, bus_if.wvalid, bus_if.bready});
    end
    n_cmp++;
    if ({bus_if.wb_empty, bus_if.push_ready, bus_if.chk_conflict} !== 3'b110) begin
      n_err++;
      $display("FAIL rstmid_status got=%b exp=110", {bus_if.wb_empty, bus_if.push_ready, bus_if.chk_conflict});
    end
    step();
    step();
    rst = 1'b0;
    aw_before = aw_hs_total;
    bus_if.awready = 1'b1;
    bus_if.wready = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (aw_hs_total != aw_before || bus_if.wb_empty !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_stale got=%0d writes, empty %b exp=0 writes, empty 1",
               aw_hs_total - aw_before, bus_if.wb_empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_skew();
    test_conflict();
    test_wrap();
    test_reset_mid();
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/d_write_buffer.md
Name: d_write_buffer

Overview:
- Posted-write FIFO between the write-through data cache's memory-side port and the AXI arbiter's data write channel.
- Accepts single-beat stores from the cache in one cycle, so stores never stall the pipeline unless the buffer is full.
- Drains stores in order as single-beat AXI write transactions.
- Reports whether it is empty, and whether a load address matches a pending store, so the cache can hold uncached or missing reads until the memory image is coherent.

Parameters:
- DEPTH, 8, number of store entries; power of two, at least 2.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- push_req  in  1  store request from d_cache.
- push_addr  in  32  physical byte address.
- push_size  in  2  0 = byte, 1 = half, 2 = word.
- push_strb  in  4  byte enables.
- push_data  in  32  store data, lane-aligned.
- push_ready  out  1  entry available; a push is accepted only when push_req and push_ready are both high.
- chk_addr  in  32  load address to check for conflict.
- chk_conflict  out  1  a pending or in-flight store covers the same word as chk_addr (compare bits [31:2]).
- wb_empty  out  1  no entries stored and no transaction in flight.
- awaddr  out  32  write address.
- awsize  out  3  write size; equals {1'b0, size}.
- awlen  out  4  burst length; constant 0.
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- wdata  out  32  write data.
- wstrb  out  4  write strobes.
- wlast  out  1  last beat; constant 1.
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.

Behaviour:
- Storage and pointers:
  - Circular array of DEPTH entries, each {addr, size, strb, data}.
  - wr_ptr and rd_ptr are PTR_W bits and wrap modulo DEPTH.
  - count is PTR_W+1 bits, range 0..DEPTH.
- push_ready = (count != DEPTH). It is combinational from count and does not depend on push_req.
- Push: the entry is written at wr_ptr on the clock edge, wr_ptr increments and count increments. The entry is visible to chk_conflict from the next cycle.
- Pop: occurs only on the B handshake (bvalid & bready). rd_ptr increments and count decrements.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full buffer: a pop in a given cycle does not make push_ready high in that same cycle. The push is accepted on the following cycle.
- Write FSM states: IDLE, SEND, RESP.
  - IDLE: if count != 0, go to SEND on the next edge and latch the head entry into output registers (awaddr, awsize, wdata, wstrb). awvalid and wvalid go high in SEND.
  - SEND: awvalid and wvalid are driven independently. Each drops the cycle after its own handshake; the aw_done and w_done flags record completed handshakes. Either order is allowed, as is both in the same cycle. Go to RESP once both are done.
  - RESP: bready = 1. On bvalid, pop the entry, clear aw_done and w_done, and return to IDLE.
- Minimum drain latency per entry: 3 cycles (IDLE -> SEND -> RESP -> IDLE) with zero-wait slaves.
- bresp and bid are ignored; every response retires its entry.
- The head entry stays in the FIFO until retired. The in-flight entry is therefore counted in count and in chk_conflict.
- chk_conflict is combinational: the OR over valid entries of (entry.addr[31:2] == chk_addr[31:2]). An entry i is valid when it lies between rd_ptr and wr_ptr with count > 0.
- wb_empty = (count == 0) && (state == IDLE).
- Reset values:
  - state = IDLE; wr_ptr, rd_ptr and count = 0; aw_done and w_done = 0.
  - awvalid, wvalid and bready = 0; awaddr, wdata, wstrb and awsize = 0.
  - push_ready = 1; wb_empty = 1; chk_conflict = 0.
- Reset mid-operation: all queued stores are discarded and the valid signals drop immediately (asynchronous reset). No exception or flush input exists: once a store is accepted it always completes.

Test Plan:
- Single store: push addr 0x1FC0_0100, data 0xDEADBEEF, strb 4'hF, size 2. Zero-wait slave -> awvalid and wvalid high on cycle 2 with awaddr 0x1FC0_0100, awsize 3'd2, wstrb 4'hF; bready the cycle after both handshakes; wb_empty high 3 cycles after push.
- Fill: 8 back-to-back pushes with awready held low -> push_ready low after the 8th push, a 9th push_req is ignored, and count stays 8. Release awready -> entries drain in push order; the first push after the first B handshake is accepted one cycle later.
- AW/W skew: wready is asserted 4 cycles after awready -> awvalid drops after its handshake, wvalid holds until the W handshake, and no response is taken before both complete.
- Conflict: pending store to 0x8000_0004 with size 0 -> chk_addr 0x8000_0007 gives chk_conflict = 1; chk_addr 0x8000_0008 gives 0. After B retires the entry, 0x8000_0007 gives 0.
- Wrap and simultaneous push/pop: stream 20 stores while bvalid returns every 4 cycles -> pointers wrap past 7, count never exceeds 8, and the write order and data match the push sequence exactly.
- Reset mid-transaction: assert rst in SEND -> awvalid and wvalid are 0 in the same cycle, wb_empty = 1 and push_ready = 1, and no stale write is issued after release.
